// File: rtl/fpu_sp_arb.sv
// Four-requester round-robin front end for a single-precision FPU core.
// Captures one request at a time, issues it, waits for completion or timeout, then returns the response.
module fpu_sp_arb #(
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req_valid,
    input  logic [15:0]  req_cmd,
    input  logic [127:0] req_din1,
    input  logic [127:0] req_din2,
    output logic [3:0]   req_ack,
    output logic [3:0]   rsp_valid,
    output logic [31:0]  rsp_result,
    output logic         rsp_err,
    output logic         busy,
    output logic [3:0]   fpu_cmd,
    output logic [31:0]  fpu_din1,
    output logic [31:0]  fpu_din2,
    output logic         fpu_dval,
    input  logic [31:0]  fpu_result,
    input  logic         fpu_rdy
);

    localparam logic [3:0] CMD_FPU_SP_ADD = 4'h1;
    localparam logic [3:0] CMD_FPU_SP_MUL = 4'h2;
    localparam logic [3:0] CMD_FPU_SP_DIV = 4'h3;
    localparam logic [3:0] CMD_FPU_SP_I2F = 4'h4;
    localparam logic [3:0] CMD_FPU_SP_F2I = 4'h5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [1:0]  last_grant;
    logic [1:0]  grant;
    logic [1:0]  grant_nx;
    logic        any_req;
    logic [3:0]  cmd_sel;
    logic [31:0] din1_sel;
    logic [31:0] din2_sel;
    logic [7:0]  cnt;
    logic        timeout_hit;
    logic [31:0] res_q;
    logic        err_q;

    function automatic logic is_legal(input logic [3:0] c);
        logic ok;
        case (c)
            CMD_FPU_SP_ADD, CMD_FPU_SP_MUL, CMD_FPU_SP_DIV,
            CMD_FPU_SP_I2F, CMD_FPU_SP_F2I: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Round-robin search starting one past the last winner.
    always_comb begin
        logic [1:0] idx;
        grant_nx = last_grant;
        any_req  = 1'b0;
        idx      = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = last_grant + k[1:0] + 2'd1;
            if (!any_req && req_valid[idx]) begin
                grant_nx = idx;
                any_req  = 1'b1;
            end else begin
                any_req  = any_req;
            end
        end
        cmd_sel  = req_cmd[{grant_nx, 2'b00} +: 4];
        din1_sel = req_din1[{grant_nx, 5'b00000} +: 32];
        din2_sel = req_din2[{grant_nx, 5'b00000} +: 32];
    end

    assign timeout_hit = (cnt == 8'(TIMEOUT - 1));

    // Next-state logic; a completion strobe beats a coincident timeout.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nx = is_legal(cmd_sel) ? ISSUE : RESP;
                end else begin
                    state_nx = IDLE;
                end
            end
            ISSUE: state_nx = WAIT;
            WAIT: begin
                if (fpu_rdy || timeout_hit) begin
                    state_nx = RESP;
                end else begin
                    state_nx = WAIT;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Datapath and registered outputs; the response is presented the cycle after RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 2'd3;
            grant      <= 2'd0;
            cnt        <= 8'd0;
            res_q      <= 32'd0;
            err_q      <= 1'b0;
            req_ack    <= 4'd0;
            rsp_valid  <= 4'd0;
            rsp_result <= 32'd0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            fpu_dval   <= 1'b0;
            fpu_cmd    <= 4'd0;
            fpu_din1   <= 32'd0;
            fpu_din2   <= 32'd0;
        end else begin
            req_ack   <= 4'd0;
            rsp_valid <= 4'd0;
            fpu_dval  <= 1'b0;
            busy      <= (state_nx != IDLE);
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant      <= grant_nx;
                        last_grant <= grant_nx;
                        fpu_cmd    <= cmd_sel;
                        fpu_din1   <= din1_sel;
                        fpu_din2   <= din2_sel;
                        req_ack    <= 4'(4'b0001 << grant_nx);
                        fpu_dval   <= is_legal(cmd_sel);
                        err_q      <= !is_legal(cmd_sel);
                        res_q      <= 32'd0;
                    end
                end
                ISSUE: cnt <= 8'd0;
                WAIT: begin
                    if (fpu_rdy) begin
                        res_q <= fpu_result;
                        err_q <= 1'b0;
                    end else if (timeout_hit) begin
                        res_q <= 32'd0;
                        err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    rsp_valid  <= 4'(4'b0001 << grant);
                    rsp_result <= res_q;
                    rsp_err    <= err_q;
                end
                default: ;
            endcase
        end
    end

endmodule
